// File: rtl/light_package.sv
`default_nettype none
// ============================================================================
// Module      : light_package
// Description : Shared types for the intersection model. This package holds
//               the lane light colours and the per-lane colour-sequence
//               monitor states, plus a small helper used for dequeue decisions.
//               It has no ports.
// Revision    : 1.0 - initial release
// ============================================================================
package light_package;

  // Encoding 2'd3 is intentionally left unused. An input carrying it is an
  // illegal colour: it never dequeues, and it always flags a sequence error.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } colors;

  // States of the colour-sequence monitor that runs in each lane.
  typedef enum logic [1:0] {
    MRED = 2'd0,
    MGRN = 2'd1,
    MYL1 = 2'd2,
    MYL2 = 2'd3
  } mon_state_t;

  // Only a true GREEN lets a car leave. Yellow, red and illegal codes hold the queue.
  function automatic logic is_green(input colors c);
    return (c == GREEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_if.sv
`default_nettype none
// ============================================================================
// Module      : lane_if
// Description : Bundle that connects the intersection top to one lane model.
//   master : drives light, arrive; receives sensor, q, deq, ovf_err, seq_err
//   slave  : receives light, arrive; drives sensor, q, deq, ovf_err, seq_err
//   light   - colour currently shown to the lane
//   arrive  - one car joins the queue this cycle
//   sensor  - registered vehicle-present indication
//   q       - current queue count (QW bits)
//   deq     - a car leaves the queue this cycle
//   ovf_err - sticky: an arrival was dropped because the queue was full
//   seq_err - sticky: the lane saw an illegal colour sequence
// Revision    : 1.0 - initial release
// ============================================================================
interface lane_if #(
  parameter int QW = 4
) ();
  import light_package::*;

  colors          light;
  logic           arrive;
  logic           sensor;
  logic [QW-1:0]  q;
  logic           deq;
  logic           ovf_err;
  logic           seq_err;

  modport master (
    output light, arrive,
    input  sensor, q, deq, ovf_err, seq_err
  );

  modport slave (
    input  light, arrive,
    output sensor, q, deq, ovf_err, seq_err
  );

endinterface
`default_nettype wire

// File: rtl/lane_model.sv
`default_nettype none
// ============================================================================
// Module      : lane_model
// Description : One traffic lane. It holds a saturating queue counter, a
//               registered vehicle sensor, a sticky overflow flag and a
//               colour-sequence monitor (red -> green -> yellow x2 -> red).
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - lane_if slave port (light/arrive in; sensor/q/deq/errors out)
// Revision    : 1.0 - initial release
// ============================================================================
module lane_model
  import light_package::*;
#(
  parameter int QW = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  lane_if.slave     bus
);

  localparam logic [QW-1:0] C_Q_MAX = '1;

  logic [QW-1:0] count_q, count_d;
  logic          sensor_q, sensor_d;
  logic          ovf_q, ovf_d;
  logic          deq;
  mon_state_t    mon_q;
  logic          seq_err_q;

  // deq depends only on the registered count and the light. A green light
  // on an empty queue therefore never underflows and is never counted.
  always_comb begin
    deq      = is_green(bus.light) && (count_q != '0);
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (bus.arrive && !deq) begin
      if (count_q == C_Q_MAX) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (!bus.arrive && deq) begin
      count_d = count_q - 1'b1;
    end
    // When an arrival and a departure happen in the same cycle they cancel,
    // so a full queue can accept the arrival without overflowing.
    sensor_d = (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      sensor_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      sensor_q <= sensor_d;
      ovf_q    <= ovf_d;
    end
  end

  // Colour-sequence monitor. Every illegal step returns the monitor to MRED,
  // so it can resynchronise on the next green.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mon_q     <= MRED;
      seq_err_q <= 1'b0;
    end else begin
      case (mon_q)
        MRED: begin
          if (bus.light == GREEN) begin
            mon_q <= MGRN;
          end else begin
            mon_q <= MRED;
            if (bus.light != RED) seq_err_q <= 1'b1;
          end
        end
        MGRN: begin
          if (bus.light == GREEN) begin
            mon_q <= MGRN;
          end else if (bus.light == YELLOW) begin
            mon_q <= MYL1;
          end else begin
            mon_q     <= MRED;
            seq_err_q <= 1'b1;
          end
        end
        MYL1: begin
          if (bus.light == YELLOW) begin
            mon_q <= MYL2;
          end else begin
            mon_q     <= MRED;
            seq_err_q <= 1'b1;
          end
        end
        MYL2: begin
          mon_q <= MRED;
          if (bus.light != RED) seq_err_q <= 1'b1;
        end
        default: mon_q <= MRED;
      endcase
    end
  end

  assign bus.q       = count_q;
  assign bus.sensor  = sensor_q;
  assign bus.deq     = deq;
  assign bus.ovf_err = ovf_q;
  assign bus.seq_err = seq_err_q;

endmodule
`default_nettype wire

// File: rtl/intersection_model.sv
`default_nettype none
// ============================================================================
// Module      : intersection_model
// Description : Behavioural model of a three-lane intersection (EW straight,
//               EW left, NS). It uses three lane_model instances for the
//               queues and the sequence monitors. This top level adds the
//               light-conflict check and a wrapping 16-bit departed counter.
//   clk                  - rising-edge clock
//   reset                - asynchronous active-low reset
//   *_light              - colour per lane, from the light controller
//   arrive_*             - one car arrives in that lane this cycle
//   *_sensor             - registered vehicle-present feedback
//   q_*                  - queue count per lane (QW bits)
//   departed             - total cars departed, modulo 2^16
//   conflict_err         - sticky: two or more lights not red together
//   seq_err / ovf_err    - sticky per-lane flags, {ns, ew_left, ew_str}
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_model
  import light_package::*;
#(
  parameter int QW = 4
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire colors         ew_str_light,
  input  wire colors         ew_left_light,
  input  wire colors         ns_light,
  input  wire logic          arrive_ew_str,
  input  wire logic          arrive_ew_left,
  input  wire logic          arrive_ns,
  output logic               ew_str_sensor,
  output logic               ew_left_sensor,
  output logic               ns_sensor,
  output logic [QW-1:0]      q_ew_str,
  output logic [QW-1:0]      q_ew_left,
  output logic [QW-1:0]      q_ns,
  output logic [15:0]        departed,
  output logic               conflict_err,
  output logic [2:0]         seq_err,
  output logic [2:0]         ovf_err
);

  lane_if #(.QW(QW)) ew_str_if  ();
  lane_if #(.QW(QW)) ew_left_if ();
  lane_if #(.QW(QW)) ns_if      ();

  assign ew_str_if.light   = ew_str_light;
  assign ew_str_if.arrive  = arrive_ew_str;
  assign ew_left_if.light  = ew_left_light;
  assign ew_left_if.arrive = arrive_ew_left;
  assign ns_if.light       = ns_light;
  assign ns_if.arrive      = arrive_ns;

  lane_model #(.QW(QW)) u_ew_str (
    .clk   (clk),
    .reset (reset),
    .bus   (ew_str_if)
  );

  lane_model #(.QW(QW)) u_ew_left (
    .clk   (clk),
    .reset (reset),
    .bus   (ew_left_if)
  );

  lane_model #(.QW(QW)) u_ns (
    .clk   (clk),
    .reset (reset),
    .bus   (ns_if)
  );

  logic [15:0] departed_q, departed_d;
  logic        conflict_q, conflict_d;
  logic [2:0]  not_red;
  logic [1:0]  n_deq;
  logic        multi_active;

  // An illegal colour code counts as "not red" here, because the controller
  // is not showing a clean red on that lane.
  always_comb begin
    not_red      = {ns_light != RED, ew_left_light != RED, ew_str_light != RED};
    multi_active = (not_red[0] & not_red[1]) | (not_red[0] & not_red[2]) |
                   (not_red[1] & not_red[2]);
    n_deq        = {1'b0, ew_str_if.deq} + {1'b0, ew_left_if.deq} + {1'b0, ns_if.deq};
    departed_d   = departed_q + {14'd0, n_deq};
    conflict_d   = conflict_q | multi_active;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      departed_q <= 16'd0;
      conflict_q <= 1'b0;
    end else begin
      departed_q <= departed_d;
      conflict_q <= conflict_d;
    end
  end

  assign ew_str_sensor  = ew_str_if.sensor;
  assign ew_left_sensor = ew_left_if.sensor;
  assign ns_sensor      = ns_if.sensor;
  assign q_ew_str       = ew_str_if.q;
  assign q_ew_left      = ew_left_if.q;
  assign q_ns           = ns_if.q;
  assign departed       = departed_q;
  assign conflict_err   = conflict_q;
  assign seq_err        = {ns_if.seq_err, ew_left_if.seq_err, ew_str_if.seq_err};
  assign ovf_err        = {ns_if.ovf_err, ew_left_if.ovf_err, ew_str_if.ovf_err};

endmodule
`default_nettype wire

// File: tb/tb_intersection_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_model
// Description : Self-checking bench for intersection_model. It applies a
//               table of directed vectors, followed by hand-written sequences
//               for overflow, conflict, illegal colour and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_model;
  import light_package::*;

  logic        clk = 1'b0;
  logic        reset;
  colors       ls, ll, ln;
  logic        as_, al, an;
  logic        s_s, s_l, s_n;
  logic [3:0]  q_s, q_l, q_n;
  logic [15:0] dep;
  logic        conf;
  logic [2:0]  seq, ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intersection_model #(.QW(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .ew_str_light   (ls),
    .ew_left_light  (ll),
    .ns_light       (ln),
    .arrive_ew_str  (as_),
    .arrive_ew_left (al),
    .arrive_ns      (an),
    .ew_str_sensor  (s_s),
    .ew_left_sensor (s_l),
    .ns_sensor      (s_n),
    .q_ew_str       (q_s),
    .q_ew_left      (q_l),
    .q_ns           (q_n),
    .departed       (dep),
    .conflict_err   (conf),
    .seq_err        (seq),
    .ovf_err        (ovf)
  );

  typedef struct {
    colors       ls, ll, ln;
    logic        as_, al, an;
    logic [3:0]  qs, ql, qn;
    logic [2:0]  sens;
    logic [15:0] dep;
    logic        conf;
    logic [2:0]  seq, ovf;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    ls = RED; ll = RED; ln = RED;
    as_ = 1'b0; al = 1'b0; an = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " q"},    {20'd0, q_s, q_l, q_n}, 32'd0);
    chk({tag, " sens"}, {29'd0, s_n, s_l, s_s}, 32'd0);
    chk({tag, " dep"},  {16'd0, dep}, 32'd0);
    chk({tag, " err"},  {25'd0, conf, seq, ovf}, 32'd0);
  endtask

  initial begin
    //          ls     ll      ln      as al an  qs    ql    qn    sens    dep    cf    seq     ovf
    tbl[0]  = '{RED,   RED,    RED,    0, 0, 1, 4'd0, 4'd0, 4'd1, 3'b100, 16'd0, 1'b0, 3'b000, 3'b000};
    tbl[1]  = '{RED,   RED,    RED,    0, 0, 1, 4'd0, 4'd0, 4'd2, 3'b100, 16'd0, 1'b0, 3'b000, 3'b000};
    tbl[2]  = '{RED,   RED,    RED,    0, 0, 1, 4'd0, 4'd0, 4'd3, 3'b100, 16'd0, 1'b0, 3'b000, 3'b000};
    tbl[3]  = '{RED,   RED,    GREEN,  0, 0, 0, 4'd0, 4'd0, 4'd2, 3'b100, 16'd1, 1'b0, 3'b000, 3'b000};
    tbl[4]  = '{RED,   RED,    GREEN,  0, 0, 0, 4'd0, 4'd0, 4'd1, 3'b100, 16'd2, 1'b0, 3'b000, 3'b000};
    tbl[5]  = '{RED,   RED,    GREEN,  0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd3, 1'b0, 3'b000, 3'b000};
    tbl[6]  = '{RED,   RED,    GREEN,  0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd3, 1'b0, 3'b000, 3'b000};
    tbl[7]  = '{RED,   RED,    GREEN,  0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd3, 1'b0, 3'b000, 3'b000};
    tbl[8]  = '{RED,   RED,    YELLOW, 0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd3, 1'b0, 3'b000, 3'b000};
    tbl[9]  = '{RED,   RED,    YELLOW, 0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd3, 1'b0, 3'b000, 3'b000};
    tbl[10] = '{RED,   RED,    RED,    0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd3, 1'b0, 3'b000, 3'b000};
    tbl[11] = '{RED,   GREEN,  RED,    0, 1, 0, 4'd0, 4'd1, 4'd0, 3'b010, 16'd3, 1'b0, 3'b000, 3'b000};
    tbl[12] = '{RED,   GREEN,  RED,    0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd4, 1'b0, 3'b000, 3'b000};
    tbl[13] = '{RED,   YELLOW, RED,    0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd4, 1'b0, 3'b000, 3'b000};
    tbl[14] = '{RED,   RED,    RED,    0, 0, 0, 4'd0, 4'd0, 4'd0, 3'b000, 16'd4, 1'b0, 3'b010, 3'b000};
    tbl[15] = '{RED,   RED,    RED,    1, 1, 1, 4'd1, 4'd1, 4'd1, 3'b111, 16'd4, 1'b0, 3'b010, 3'b000};

    idle();
    reset = 1'b0;
    #2;
    // Check the outputs while reset is held low.
    chk_all_zero("reset");
    do_reset();
    chk_all_zero("post_reset");

    // Table: NS fill/drain, NS G..Y,Y,R legal, EW-left G,G,Y,R illegal.
    for (int i = 0; i < 16; i++) begin
      ls = tbl[i].ls; ll = tbl[i].ll; ln = tbl[i].ln;
      as_ = tbl[i].as_; al = tbl[i].al; an = tbl[i].an;
      step();
      chk($sformatf("row%0d q_s", i), {28'd0, q_s}, {28'd0, tbl[i].qs});
      chk($sformatf("row%0d q_l", i), {28'd0, q_l}, {28'd0, tbl[i].ql});
      chk($sformatf("row%0d q_n", i), {28'd0, q_n}, {28'd0, tbl[i].qn});
      chk($sformatf("row%0d sens", i), {29'd0, s_n, s_l, s_s}, {29'd0, tbl[i].sens});
      chk($sformatf("row%0d dep", i), {16'd0, dep}, {16'd0, tbl[i].dep});
      chk($sformatf("row%0d conf", i), {31'd0, conf}, {31'd0, tbl[i].conf});
      chk($sformatf("row%0d seq", i), {29'd0, seq}, {29'd0, tbl[i].seq});
      chk($sformatf("row%0d ovf", i), {29'd0, ovf}, {29'd0, tbl[i].ovf});
    end

    // Overflow: 16 arrivals under red saturate at 15. Arrive+green at full holds.
    do_reset();
    as_ = 1'b1;
    repeat (15) step();
    chk("ovf q15", {28'd0, q_s}, 32'd15);
    chk("ovf none yet", {29'd0, ovf}, 32'd0);
    step();
    chk("ovf q sat", {28'd0, q_s}, 32'd15);
    chk("ovf flag", {29'd0, ovf}, 32'b001);
    ls = GREEN;
    step();
    chk("arr+deq q", {28'd0, q_s}, 32'd15);
    chk("arr+deq dep", {16'd0, dep}, 32'd1);
    chk("arr+deq ovf", {29'd0, ovf}, 32'b001);
    as_ = 1'b0;
    step();
    chk("drain q", {28'd0, q_s}, 32'd14);
    chk("drain dep", {16'd0, dep}, 32'd2);
    chk("drain sens", {31'd0, s_s}, 32'd1);
    ls = YELLOW; step(); step();
    ls = RED; step();
    chk("ew_s seq ok", {29'd0, seq}, 32'd0);
    chk("ew_s ovf sticky", {29'd0, ovf}, 32'b001);

    // Conflict: one green alone is fine. Green plus yellow sets a sticky flag.
    do_reset();
    ls = GREEN;
    step();
    chk("single green conf", {31'd0, conf}, 32'd0);
    ln = YELLOW;
    step();
    chk("conflict set", {31'd0, conf}, 32'd1);
    idle();
    step();
    chk("conflict held", {31'd0, conf}, 32'd1);
    chk("conflict seq", {29'd0, seq}, 32'b101);
    repeat (3) step();
    chk("conflict still", {31'd0, conf}, 32'd1);

    // Illegal colour code: no dequeue, and the monitor flags a sequence error.
    do_reset();
    an = 1'b1;
    step();
    an = 1'b0;
    ln = colors'(2'd3);
    step();
    chk("bad light q", {28'd0, q_n}, 32'd1);
    chk("bad light dep", {16'd0, dep}, 32'd0);
    chk("bad light seq", {29'd0, seq}, 32'b100);

    // Async reset mid-queue with errors set.
    do_reset();
    an = 1'b1;
    repeat (8) step();
    an = 1'b0;
    ln = GREEN;
    step();
    chk("pre q_n", {28'd0, q_n}, 32'd7);
    chk("pre dep", {16'd0, dep}, 32'd1);
    ln = YELLOW; ll = YELLOW;
    step();
    chk("pre q_n hold", {28'd0, q_n}, 32'd7);
    chk("pre seq", {29'd0, seq}, 32'b010);
    chk("pre conf", {31'd0, conf}, 32'd1);
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("async");
    idle();
    an = 1'b1;
    @(posedge clk);
    #1;
    chk("reset holds", {28'd0, q_n}, 32'd0);
    reset = 1'b1;
    step();
    chk("first update", {28'd0, q_n}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
